implication_monitor: RTL and testbench
======================================

# implication_monitor

Synthesizable, parametrised runtime checker for the property "antecedent implies consequent within `##[MIN_DELAY:MAX_DELAY]`", replicated over `N_CH` independent channels. It extends the fixed overlapping (`|->`) and non-overlapping (`|=>`) forms to an arbitrary bounded window with overlapping evaluation threads, per-channel pass/fail pulses, saturating counters and sticky error flags. It sits beside the logic it observes, in silicon or in formal/simulation harnesses, so implication coverage and failures are visible as registers instead of only as simulator messages.

## Interface
- `N_CH`, 4: number of independent channels.
- `MIN_DELAY`, 0: earliest cycle offset at which the consequent satisfies a thread. 0 gives overlapping behaviour, 1 gives non-overlapping.
- `MAX_DELAY`, 1: latest cycle offset. The block requires 0 ≤ MIN_DELAY ≤ MAX_DELAY ≤ 15 and raises an elaboration error otherwise.
- `CNT_W`, 16: width of each pass and fail counter.

Ports:
- `clk` in 1: the single clock. All logic samples on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `en_i` in 1: while low, new antecedents are ignored; threads already open keep evaluating.
- `clr_i` in 1: synchronous clear of threads, counters and sticky flags.
- `antecedent_i` in N_CH: antecedent, one bit per channel.
- `consequent_i` in N_CH: consequent, one bit per channel.
- `pass_o` out N_CH: one-cycle pulse when at least one thread passed.
- `fail_o` out N_CH: one-cycle pulse when a thread failed.
- `pass_cnt_o` out N_CH*CNT_W: saturating pass counts. Channel c occupies bits [c*CNT_W +: CNT_W].
- `fail_cnt_o` out N_CH*CNT_W: saturating fail counts, same packing.
- `err_sticky_o` out N_CH: set on the first fail and held until clear.
- `pending_o` out N_CH: at least one thread is open.

## Operation
- Each channel holds a live vector `live[0..MAX_DELAY]`. Bit k set means an open thread that has reached age k at the next edge.
- At every edge, form the candidate vector: `cand[0] = antecedent_i & en_i`, and `cand[k] = live[k-1]` for k ≥ 1.
- For each candidate age a:
  - a ≥ MIN_DELAY and `consequent_i` = 1: the thread passes and is removed.
  - otherwise, a == MAX_DELAY: the thread fails and is removed.
  - otherwise: the thread survives as `live[a]`.
- Several threads may pass at the same edge. `pass_cnt` increases by their popcount, which has width clog2(MAX_DELAY+2).
- At most one thread fails per edge per channel (the one at age MAX_DELAY). `fail_cnt` increases by 1.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `err_sticky_o` is set by any fail and cleared only by `clr_i` or reset.
- `pending_o = |live`.
- `rst_n` = 0 or `clr_i` = 1 at an edge:
  - every live bit, counter, sticky flag and pulse goes to 0;
  - events sampled at that edge are discarded;
  - reset takes priority over clear, with an identical effect.
- A reset or clear in the middle of a window silently drops open threads. No fail is reported for them.
- Channels are fully independent. There are no cross-channel interactions.

## Timing
- Every output is registered, and every output is 0 after reset.
- Latency: a pass or fail decided at edge t appears on `pass_o`/`fail_o` and the counters during cycle t+1.
- MIN_DELAY = 0, MAX_DELAY = 0: a thread is opened and decided at the same edge. This is `|->`.
- MIN_DELAY = MAX_DELAY = 1: the consequent is checked exactly one edge after the antecedent. This is `|=>`.
- Antecedent and consequent high on the same edge with MIN_DELAY = 0 gives an immediate pass. No thread is left pending.
- If a pass and a fail occur at the same edge (different threads), both pulses assert and both counters update.
- A consequent with no open thread has no effect. No vacuous counting.

## Structure
- Package `implication_monitor_pkg`:
  - `MAX_DELAY_LIMIT` = 15;
  - the typedef for the live-vector width;
  - the typedef for the per-edge pass-count width.
- Sub-module `implication_monitor_ch`: one channel (live vector, decide logic, counters, sticky flag). The top level instantiates it N_CH times with a generate loop and packs the counter outputs.

## Test plan
- MIN 0 / MAX 0, channel 0. Antecedent and consequent high at edge 1 → `pass_o[0]` = 1 in cycle 2 and `pass_cnt[0]` = 1. Antecedent high with consequent low at edge 3 → `fail_o[0]` = 1, `fail_cnt[0]` = 1, `err_sticky_o[0]` = 1.
- MIN 1 / MAX 1:
  - antecedent at edge 1, consequent only at edge 1 → fail decided at edge 2;
  - consequent at edge 2 instead → pass, `pending_o` = 0 afterwards.
- MIN 1 / MAX 3. Antecedent at edges 1, 2 and 3, consequent only at edge 4 → `pass_cnt` jumps 0→3 in one cycle and there is no fail.
- MIN 1 / MAX 3. Antecedent at edge 1, consequent never → fail at edge 4. `pending_o` is high during edges 2-4 and 0 afterwards.
- CNT_W = 4. Apply 20 consecutive failing threads → `fail_cnt` = 15, held.
- Antecedent at edge 1 with MAX 3, then `clr_i` at edge 2 (repeat with `rst_n` low) → no fail, all counters and flags 0. Also, antecedent with `en_i` = 0 → no thread opened and `pending_o` stays 0.

Source files
------------

// File: rtl/implication_monitor_pkg.sv
// Shared limits and widths for the bounded-window implication monitor.
package implication_monitor_pkg;

  localparam int MAX_DELAY_LIMIT = 15;
  localparam int LIVE_W          = MAX_DELAY_LIMIT + 1;
  // Enough bits to count every thread in a full window passing on one edge.
  localparam int PCNT_W          = $clog2(MAX_DELAY_LIMIT + 2);

  typedef logic [LIVE_W-1:0] live_t;
  typedef logic [PCNT_W-1:0] pcnt_t;

endpackage

// File: rtl/implication_monitor_ch.sv
// One channel: open-thread vector, per-edge pass/fail decision,
// saturating counters and sticky error flag.
module implication_monitor_ch
  import implication_monitor_pkg::*;
#(
  parameter int MIN_DELAY = 0,
  parameter int MAX_DELAY = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             antecedent,
  input  logic             consequent,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic             pending
);

  localparam int SW = CNT_W + PCNT_W;
  localparam logic [SW-1:0] CMAX = SW'({CNT_W{1'b1}});

  live_t              live, live_nxt;
  logic [MAX_DELAY:0] cand, pass_v;
  logic               fail_nxt;
  pcnt_t              npass;
  logic [SW-1:0]      psum, fsum;
  logic [CNT_W-1:0]   pass_cnt_nxt, fail_cnt_nxt;

  // Each candidate is a thread one age older than last edge; age 0 is a new antecedent.
  always_comb begin
    cand     = '0;
    pass_v   = '0;
    live_nxt = '0;
    fail_nxt = 1'b0;
    npass    = '0;
    cand[0]  = antecedent & en;
    for (int k = 1; k <= MAX_DELAY; k++) cand[k] = live[k-1];
    for (int a = 0; a <= MAX_DELAY; a++) begin
      if (cand[a] && a >= MIN_DELAY && consequent) pass_v[a] = 1'b1;
      else if (cand[a] && a == MAX_DELAY)          fail_nxt  = 1'b1;
      else if (cand[a])                            live_nxt[a] = 1'b1;
    end
    for (int a = 0; a <= MAX_DELAY; a++) npass = npass + pcnt_t'(pass_v[a]);
  end

  always_comb begin
    psum         = SW'(pass_cnt) + SW'(npass);
    fsum         = SW'(fail_cnt) + SW'(fail_nxt);
    pass_cnt_nxt = (psum > CMAX) ? CNT_W'(CMAX) : CNT_W'(psum);
    fail_cnt_nxt = (fsum > CMAX) ? CNT_W'(CMAX) : CNT_W'(fsum);
  end

  // Clear behaves exactly like reset: open threads are dropped silently.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      live       <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      live       <= live_nxt;
      pass       <= |pass_v;
      fail       <= fail_nxt;
      pass_cnt   <= pass_cnt_nxt;
      fail_cnt   <= fail_cnt_nxt;
      err_sticky <= err_sticky | fail_nxt;
    end
  end

  assign pending = |live;

endmodule

// File: rtl/implication_monitor.sv
// Runtime checker for "antecedent |-> ##[MIN_DELAY:MAX_DELAY] consequent"
// over N_CH independent channels.
module implication_monitor
  import implication_monitor_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int MIN_DELAY = 0,
  parameter int MAX_DELAY = 1,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [N_CH-1:0]       antecedent_i,
  input  logic [N_CH-1:0]       consequent_i,
  output logic [N_CH-1:0]       pass_o,
  output logic [N_CH-1:0]       fail_o,
  output logic [N_CH*CNT_W-1:0] pass_cnt_o,
  output logic [N_CH*CNT_W-1:0] fail_cnt_o,
  output logic [N_CH-1:0]       err_sticky_o,
  output logic [N_CH-1:0]       pending_o
);

  if (MIN_DELAY < 0 || MIN_DELAY > MAX_DELAY || MAX_DELAY > MAX_DELAY_LIMIT) begin : g_bad_cfg
    $error("implication_monitor: need 0 <= MIN_DELAY <= MAX_DELAY <= %0d", MAX_DELAY_LIMIT);
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    implication_monitor_ch #(
      .MIN_DELAY (MIN_DELAY),
      .MAX_DELAY (MAX_DELAY),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en_i),
      .clr        (clr_i),
      .antecedent (antecedent_i[c]),
      .consequent (consequent_i[c]),
      .pass       (pass_o[c]),
      .fail       (fail_o[c]),
      .pass_cnt   (pass_cnt_o[c*CNT_W +: CNT_W]),
      .fail_cnt   (fail_cnt_o[c*CNT_W +: CNT_W]),
      .err_sticky (err_sticky_o[c]),
      .pending    (pending_o[c])
    );
  end

endmodule

// File: tb/tb_implication_monitor.sv
// Three monitor configurations share one stimulus stream; a thread-list model
// predicts every output each cycle, and literal checks pin key scenarios.
module tb_implication_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en_i, clr_i;
  logic [3:0] ant, cons;

  logic [3:0]  p0, f0, s0, pd0, p1, f1, s1, pd1, p3, f3, s3, pd3;
  logic [15:0] pc0, fc0;
  logic [63:0] pc1, fc1, pc3, fc3;

  implication_monitor #(.N_CH(4), .MIN_DELAY(0), .MAX_DELAY(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .antecedent_i(ant),
    .consequent_i(cons), .pass_o(p0), .fail_o(f0), .pass_cnt_o(pc0), .fail_cnt_o(fc0),
    .err_sticky_o(s0), .pending_o(pd0));
  implication_monitor #(.N_CH(4), .MIN_DELAY(1), .MAX_DELAY(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .antecedent_i(ant),
    .consequent_i(cons), .pass_o(p1), .fail_o(f1), .pass_cnt_o(pc1), .fail_cnt_o(fc1),
    .err_sticky_o(s1), .pending_o(pd1));
  implication_monitor #(.N_CH(4), .MIN_DELAY(1), .MAX_DELAY(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .antecedent_i(ant),
    .consequent_i(cons), .pass_o(p3), .fail_o(f3), .pass_cnt_o(pc3), .fail_cnt_o(fc3),
    .err_sticky_o(s3), .pending_o(pd3));

  int n_chk = 0;
  int n_fail = 0;
  bit done = 1'b0;

  // Model: per channel a list of edge numbers at which open threads started.
  int mins[3] = '{0, 1, 1};
  int maxs[3] = '{0, 1, 3};
  int cmax[3] = '{15, 65535, 65535};
  int q[12][$];
  int e_pc[12], e_fc[12];
  bit e_p[12], e_f[12], e_s[12];
  int tedge = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step();
    int keep[$];
    int np, age, i;
    bit fl;
    tedge++;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        i = d*4 + c;
        if (!rst_n || clr_i) begin
          q[i].delete();
          e_pc[i] = 0; e_fc[i] = 0; e_p[i] = 0; e_f[i] = 0; e_s[i] = 0;
        end else begin
          keep.delete();
          np = 0; fl = 0;
          if (ant[c] && en_i) q[i].push_back(tedge);
          for (int j = 0; j < q[i].size(); j++) begin
            age = tedge - q[i][j];
            if (age >= mins[d] && cons[c]) np++;
            else if (age == maxs[d]) fl = 1;
            else keep.push_back(q[i][j]);
          end
          q[i] = keep;
          e_pc[i] = (e_pc[i] + np > cmax[d]) ? cmax[d] : e_pc[i] + np;
          if (fl && e_fc[i] < cmax[d]) e_fc[i] = e_fc[i] + 1;
          e_s[i] = e_s[i] | fl;
          e_p[i] = (np > 0);
          e_f[i] = fl;
        end
      end
    end
  endtask

  task automatic cmp_all();
    int i, apc, afc;
    logic ap, af, as, apd;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        i = d*4 + c;
        case (d)
          0: begin ap = p0[c]; af = f0[c]; as = s0[c]; apd = pd0[c];
                   apc = int'(pc0[c*4 +: 4]); afc = int'(fc0[c*4 +: 4]); end
          1: begin ap = p1[c]; af = f1[c]; as = s1[c]; apd = pd1[c];
                   apc = int'(pc1[c*16 +: 16]); afc = int'(fc1[c*16 +: 16]); end
          default: begin ap = p3[c]; af = f3[c]; as = s3[c]; apd = pd3[c];
                   apc = int'(pc3[c*16 +: 16]); afc = int'(fc3[c*16 +: 16]); end
        endcase
        chk($sformatf("d%0d_ch%0d_pass", d, c), int'(ap), int'(e_p[i]));
        chk($sformatf("d%0d_ch%0d_fail", d, c), int'(af), int'(e_f[i]));
        chk($sformatf("d%0d_ch%0d_sticky", d, c), int'(as), int'(e_s[i]));
        chk($sformatf("d%0d_ch%0d_pending", d, c), int'(apd), int'(q[i].size() > 0));
        chk($sformatf("d%0d_ch%0d_pass_cnt", d, c), apc, e_pc[i]);
        chk($sformatf("d%0d_ch%0d_fail_cnt", d, c), afc, e_fc[i]);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!done) cmp_all();
    end
  end

  task automatic cyc(input logic [3:0] a, input logic [3:0] c, input logic e = 1'b1,
                     input logic cl = 1'b0, input logic r = 1'b1);
    ant = a; cons = c; en_i = e; clr_i = cl; rst_n = r;
    @(negedge clk);
  endtask

  task automatic clear();
    cyc(4'h0, 4'h0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [7:0] v;
    ant = '0; cons = '0; en_i = 1'b1; clr_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("rst_cnt0", int'(pc0), 0);
    chk("rst_fcnt3", int'(fc3[31:0]), 0);
    chk("rst_pend3", int'(pd3), 0);
    chk("rst_sticky1", int'(s1), 0);

    // |-> : pass then fail on channel 0
    cyc(4'h1, 4'h1);
    chk("ovl_pass", int'(p0[0]), 1);
    chk("ovl_pass_cnt", int'(pc0[3:0]), 1);
    cyc(4'h0, 4'h0);
    chk("ovl_pulse_drop", int'(p0[0]), 0);
    cyc(4'h1, 4'h0);
    chk("ovl_fail", int'(f0[0]), 1);
    chk("ovl_fail_cnt", int'(fc0[3:0]), 1);
    chk("ovl_sticky", int'(s0[0]), 1);
    clear();

    // |=> : same-edge consequent does not count, next edge decides
    cyc(4'h1, 4'h1);
    chk("novl_pend", int'(pd1[0]), 1);
    chk("novl_nopass", int'(p1[0]), 0);
    cyc(4'h0, 4'h0);
    chk("novl_fail", int'(f1[0]), 1);
    chk("novl_fail_cnt", int'(fc1[15:0]), 1);
    clear();
    cyc(4'h1, 4'h0);
    cyc(4'h0, 4'h1);
    chk("novl_pass", int'(p1[0]), 1);
    chk("novl_pass_cnt", int'(pc1[15:0]), 1);
    chk("novl_pend_after", int'(pd1[0]), 0);
    clear();

    // window 1..3: three overlapping threads pass on one edge
    repeat (3) cyc(4'h1, 4'h0);
    chk("multi_pre_cnt", int'(pc3[15:0]), 0);
    chk("multi_pend", int'(pd3[0]), 1);
    cyc(4'h0, 4'h1);
    chk("multi_pass_cnt", int'(pc3[15:0]), 3);
    chk("multi_pass", int'(p3[0]), 1);
    chk("multi_nofail", int'(f3[0]), 0);
    chk("multi_pend_after", int'(pd3[0]), 0);
    clear();

    // window 1..3: timeout fail at age 3
    cyc(4'h1, 4'h0);
    chk("to_pend1", int'(pd3[0]), 1);
    cyc(4'h0, 4'h0);
    chk("to_pend2", int'(pd3[0]), 1);
    cyc(4'h0, 4'h0);
    chk("to_pend3", int'(pd3[0]), 1);
    chk("to_nofail", int'(f3[0]), 0);
    cyc(4'h0, 4'h0);
    chk("to_fail", int'(f3[0]), 1);
    chk("to_pend_after", int'(pd3[0]), 0);
    chk("to_sticky", int'(s3[0]), 1);
    clear();

    // saturation at 15 with a 4-bit counter
    repeat (20) cyc(4'h1, 4'h0);
    chk("sat_fail_cnt", int'(fc0[3:0]), 15);
    cyc(4'h0, 4'h0);
    chk("sat_hold", int'(fc0[3:0]), 15);
    chk("sat_other_ch", int'(fc0[7:4]), 0);
    clear();

    // clear and reset mid-window drop threads without a fail
    cyc(4'h1, 4'h0);
    clear();
    chk("clr_pend", int'(pd3[0]), 0);
    repeat (4) cyc(4'h0, 4'h0);
    chk("clr_nofail", int'(fc3[15:0]), 0);
    chk("clr_nosticky", int'(s3[0]), 0);
    cyc(4'h1, 4'h0);
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_pend", int'(pd3[0]), 0);
    repeat (4) cyc(4'h0, 4'h0);
    chk("rst_mid_nofail", int'(fc3[15:0]), 0);

    // disabled antecedent opens nothing
    cyc(4'hF, 4'h0, 1'b0);
    chk("en_off_pend3", int'(pd3), 0);
    chk("en_off_pend1", int'(pd1), 0);
    repeat (4) cyc(4'h0, 4'h0);
    chk("en_off_nofail", int'(fc3[31:0]), 0);

    // mixed multi-channel traffic, checked by the model
    for (int i = 0; i < 48; i++) begin
      v = 8'(i*37 + 11);
      cyc(v[3:0], v[7:4], (i % 9) != 8, i == 25);
    end
    repeat (4) cyc(4'h0, 4'h0);

    done = 1'b1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
